// File: rtl/mips_pkg.sv
// mips_pkg: shared next-PC select codes, reset PC and nop constant
package mips_pkg;
  localparam logic [2:0] NPC_PC4 = 3'd0;
  localparam logic [2:0] NPC_BR = 3'd1;
  localparam logic [2:0] NPC_J = 3'd2;
  localparam logic [2:0] NPC_JR = 3'd3;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP = 32'h0;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with stall hold and bubble clear
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        clr,
  input  logic [31:0] ir_f,
  input  logic [31:0] pc_f,
  input  logic [31:0] pc4_f,
  output logic [31:0] ir_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc4_d
);
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_d <= NOP;
      pc_d <= '0;
      pc4_d <= '0;
    end else if (!stall) begin
      ir_d <= clr ? NOP : ir_f;
      pc_d <= pc_f;
      pc4_d <= pc4_f;
    end
  end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch-stage PC owner with next-PC select, IF/ID register, misalign flag and stall counter
module pc_fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             clr_D,
  input  logic [2:0]       NPC_sel,
  input  logic             br_taken,
  input  logic [31:0]      npc_b,
  input  logic [31:0]      npc_j,
  input  logic [31:0]      npc_jr,
  input  logic [31:0]      IR_F,
  output logic [31:0]      PC_F,
  output logic [31:0]      IR_D,
  output logic [31:0]      PC_D,
  output logic [31:0]      PC4_D,
  output logic             misalign,
  output logic [CNT_W-1:0] stall_cnt
);
  logic [31:0] pc4, raw;
  logic        br, redir;
  always_comb begin
    pc4 = PC_F + 32'd4;
    br = NPC_sel == NPC_BR && br_taken;
    redir = br || NPC_sel == NPC_J || NPC_sel == NPC_JR;
    raw = NPC_sel == NPC_J ? npc_j : NPC_sel == NPC_JR ? npc_jr : br ? npc_b : pc4;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      PC_F <= RESET_PC;
      misalign <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (!stall) begin
        PC_F <= {raw[31:2], 2'b00};
        if (redir && |raw[1:0]) misalign <= 1'b1;
      end
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
  if_id_reg u_if_id (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .clr(clr_D),
    .ir_f(IR_F),
    .pc_f(PC_F),
    .pc4_f(pc4),
    .ir_d(IR_D),
    .pc_d(PC_D),
    .pc4_d(PC4_D)
  );
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed plan plus randomized run against a behavioural model
module tb_pc_fetch_ctrl;
  logic clk = 0;
  logic reset, stall, clr_D, br_taken;
  logic [2:0] NPC_sel;
  logic [31:0] npc_b, npc_j, npc_jr, IR_F;
  logic [31:0] PC_F, IR_D, PC_D, PC4_D, stall_cnt;
  logic misalign;
  logic [31:0] m_pc, m_ir, m_pcd, m_pc4d, m_cnt, saved;
  logic m_mis;
  int total = 0, bad = 0;
  pc_fetch_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .clr_D(clr_D), .NPC_sel(NPC_sel),
    .br_taken(br_taken), .npc_b(npc_b), .npc_j(npc_j), .npc_jr(npc_jr), .IR_F(IR_F),
    .PC_F(PC_F), .IR_D(IR_D), .PC_D(PC_D), .PC4_D(PC4_D), .misalign(misalign),
    .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [2:0] sel, input logic bt, input logic [31:0] b,
                       input logic [31:0] j, input logic [31:0] jr, input logic st, input logic clr);
    NPC_sel = sel; br_taken = bt; npc_b = b; npc_j = j; npc_jr = jr;
    stall = st; clr_D = clr; IR_F = $urandom;
  endtask
  task automatic tick();
    logic [31:0] tgt;
    logic redir;
    redir = 1'b1;
    if (NPC_sel == 3'd2) tgt = npc_j;
    else if (NPC_sel == 3'd3) tgt = npc_jr;
    else if (NPC_sel == 3'd1 && br_taken) tgt = npc_b;
    else begin tgt = m_pc + 32'd4; redir = 1'b0; end
    @(posedge clk); #1;
    if (reset) begin
      m_pc = 32'h3000; m_ir = 0; m_pcd = 0; m_pc4d = 0; m_mis = 0; m_cnt = 0;
    end else if (stall) begin
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else begin
      m_ir = clr_D ? 32'h0 : IR_F;
      m_pcd = m_pc;
      m_pc4d = m_pc + 32'd4;
      m_pc = tgt & ~32'h3;
      if (redir && tgt[1:0] != 2'b00) m_mis = 1'b1;
    end
    chk("pc_f", PC_F, m_pc);
    chk("ir_d", IR_D, m_ir);
    chk("pc_d", PC_D, m_pcd);
    chk("pc4_d", PC4_D, m_pc4d);
    chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
    chk("stall_cnt", stall_cnt, m_cnt);
  endtask
  initial begin
    reset = 1; drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t1_reset_pc", PC_F, 32'h3000);
    chk("t1_reset_ir", IR_D, 32'h0);
    reset = 0;
    tick();
    chk("t1_pc1", PC_F, 32'h3004);
    chk("t1_pcd", PC_D, 32'h3000);
    chk("t1_pc4d", PC4_D, 32'h3004);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t1_pc2", PC_F, 32'h3008);
    drive(2, 0, 0, 32'h3100, 0, 0, 0); saved = IR_F;
    tick();
    chk("t2_jump", PC_F, 32'h3100);
    chk("t2_delay_slot", IR_D, saved);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t2_pcd", PC_D, 32'h3100);
    drive(1, 0, 32'h3200, 0, 0, 0, 0);
    tick();
    chk("t3_not_taken", PC_F, 32'h3108);
    drive(1, 1, 32'h3200, 0, 0, 0, 0);
    tick();
    chk("t3_taken", PC_F, 32'h3200);
    saved = IR_D;
    for (int i = 0; i < 4; i++) begin
      drive(3, 0, 0, 0, 32'h4000, 1, 0);
      tick();
      chk("t4_hold_pc", PC_F, 32'h3200);
      chk("t4_hold_ir", IR_D, saved);
    end
    chk("t4_cnt", stall_cnt, 32'd4);
    drive(3, 0, 0, 0, 32'h4000, 0, 0);
    tick();
    chk("t4_release", PC_F, 32'h4000);
    drive(3, 0, 0, 0, 32'h4002, 0, 0);
    tick();
    chk("t5_aligned", PC_F, 32'h4000);
    chk("t5_mis", {31'b0, misalign}, 32'd1);
    drive(2, 0, 0, 32'h5000, 0, 0, 0);
    tick();
    chk("t5_sticky", {31'b0, misalign}, 32'd1);
    reset = 1; tick(); reset = 0;
    chk("t5_clear", {31'b0, misalign}, 32'd0);
    drive(3, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t6_wrap", PC_F, 32'h0);
    saved = IR_D;
    drive(0, 0, 0, 0, 0, 1, 1);
    tick();
    chk("t6_stall_clr", IR_D, saved);
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("t6_clr", IR_D, 32'h0);
    drive(3, 0, 0, 0, 32'h7000, 1, 0);
    tick();
    reset = 1; tick(); reset = 0;
    chk("t6_reset_stall", PC_F, 32'h3000);
    chk("t6_reset_cnt", stall_cnt, 32'd0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] b, j, jr;
      b = $urandom; j = $urandom; jr = $urandom;
      if ($urandom_range(0, 2) != 0) begin b[1:0] = 0; j[1:0] = 0; jr[1:0] = 0; end
      drive(3'($urandom_range(0, 7)), 1'($urandom), b, j, jr,
            $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
      reset = $urandom_range(0, 49) == 0;
      tick();
    end
    reset = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
